// File: rtl/lab1_imul_int_mul_arbiter.sv
// lab1_imul_int_mul_arbiter: round-robin arbiter sharing one iterative multiplier among NREQS requesters.
// Define LAB1_IMUL_ARB_PERF_EN to add the saturating perf_txns / perf_busy counters.
module lab1_imul_int_mul_arbiter #(
    parameter int NREQS = 4,
    parameter int NBITS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQS-1:0]         req_val,
    output logic [NREQS-1:0]         req_rdy,
    input  logic [NREQS*2*NBITS-1:0] req_msg,
    output logic [NREQS-1:0]         resp_val,
    input  logic [NREQS-1:0]         resp_rdy,
    output logic [NBITS-1:0]         resp_msg,
    output logic                     mul_req_val,
    input  logic                     mul_req_rdy,
    output logic [2*NBITS-1:0]       mul_req_msg,
    input  logic                     mul_resp_val,
    output logic                     mul_resp_rdy,
    input  logic [NBITS-1:0]         mul_resp_msg
`ifdef LAB1_IMUL_ARB_PERF_EN
    ,
    output logic [15:0]              perf_txns,
    output logic [31:0]              perf_busy
`endif
);
    localparam int PW = $clog2(NREQS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] win;
    logic [PW-1:0] nxt_ptr;
    logic [PW:0]   idx;
    logic          idle;
    logic          busy;
    logic          grant;
    logic          done;

    // Reset (active low) masks every handshake output immediately.
    assign idle = reset && (state == IDLE);
    assign busy = reset && (state == BUSY);

    // Scan from ptr downward in priority so the closest valid index after ptr wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            idx = (idx >= (PW+1)'(NREQS)) ? idx - (PW+1)'(NREQS) : idx;
            if (req_val[idx[PW-1:0]]) win = idx[PW-1:0];
        end
    end

    // Steer the winner's operands to the multiplier, zero when nobody asks.
    always_comb begin
        mul_req_msg = '0;
        for (int i = 0; i < NREQS; i++)
            if (|req_val && win == PW'(i)) mul_req_msg = req_msg[i*2*NBITS +: 2*NBITS];
    end

    // Route the ready back to the winner and the response valid to the owner only.
    always_comb begin
        req_rdy  = '0;
        resp_val = '0;
        for (int i = 0; i < NREQS; i++) begin
            req_rdy[i]  = idle && |req_val && win == PW'(i) && mul_req_rdy;
            resp_val[i] = busy && owner == PW'(i) && mul_resp_val;
        end
    end

    assign mul_req_val  = idle && |req_val;
    assign mul_resp_rdy = busy && resp_rdy[owner];
    assign resp_msg     = mul_resp_msg;
    assign grant        = mul_req_val && mul_req_rdy;
    assign done         = mul_resp_val && mul_resp_rdy;
    assign nxt_ptr      = (win == PW'(NREQS - 1)) ? '0 : win + PW'(1);

    // Grant moves ownership and the priority pointer; the response fire frees the multiplier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else if (state == IDLE) begin
            if (grant) begin
                owner <= win;
                ptr   <= nxt_ptr;
                state <= BUSY;
            end
        end else if (done) begin
            state <= IDLE;
        end
    end

`ifdef LAB1_IMUL_ARB_PERF_EN
    // Saturating counters of completed transactions and occupied cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_txns <= '0;
            perf_busy <= '0;
        end else begin
            perf_txns <= (done && !(&perf_txns)) ? perf_txns + 16'd1 : perf_txns;
            perf_busy <= (state == BUSY && !(&perf_busy)) ? perf_busy + 32'd1 : perf_busy;
        end
    end
`endif
endmodule

// File: tb/tb_lab1_imul_int_mul_arbiter.sv
// tb_lab1_imul_int_mul_arbiter: randomized self-checking bench with a behavioural multiplier and round-robin model.
module tb_lab1_imul_int_mul_arbiter;
    localparam int N  = 4;
    localparam int NB = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_val;
    logic [N-1:0]      req_rdy;
    logic [N*2*NB-1:0] req_msg;
    logic [N-1:0]      resp_val;
    logic [N-1:0]      resp_rdy;
    logic [NB-1:0]     resp_msg;
    logic              mul_req_val;
    logic              mul_req_rdy;
    logic [2*NB-1:0]   mul_req_msg;
    logic              mul_resp_val;
    logic              mul_resp_rdy;
    logic [NB-1:0]     mul_resp_msg;
`ifdef LAB1_IMUL_ARB_PERF_EN
    logic [15:0]       perf_txns;
    logic [31:0]       perf_busy;
`endif

    logic [NB-1:0] op_a [N];
    logic [NB-1:0] op_b [N];
    int errs   = 0;
    int checks = 0;
    int mptr   = 0;

    lab1_imul_int_mul_arbiter #(.NREQS(N), .NBITS(NB)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
        .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg)
`ifdef LAB1_IMUL_ARB_PERF_EN
        , .perf_txns(perf_txns), .perf_busy(perf_busy)
`endif
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_msg
        assign req_msg[g*2*NB +: 2*NB] = {op_a[g], op_b[g]};
    end

    // Behavioural multiplier: random accept stalls, random latency, holds its result until taken.
    logic          m_busy;
    logic          m_rand;
    int            m_cnt;
    logic [NB-1:0] m_res;
    assign mul_req_rdy  = !m_busy && m_rand;
    assign mul_resp_val = m_busy && m_cnt == 0;
    assign mul_resp_msg = m_res;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_rand <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
        end else begin
            m_rand <= ($urandom_range(0, 3) != 0);
            if (!m_busy && mul_req_val && mul_req_rdy) begin
                m_busy <= 1'b1;
                m_cnt  <= int'($urandom_range(0, 4));
                m_res  <= mul_req_msg[2*NB-1:NB] * mul_req_msg[NB-1:0];
            end else if (m_busy && m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end else if (mul_resp_val && mul_resp_rdy) begin
                m_busy <= 1'b0;
            end
        end
    end

    // Round-robin reference: first valid index at or after the model pointer.
    function automatic int winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        req_val  = '0;
        resp_rdy = '1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mptr = 0;
    endtask

    task automatic serve(input int nt, input bit keep);
        int            n;
        int            w;
        logic [N-1:0]  oh;
        logic [NB-1:0] ea;
        logic [NB-1:0] eb;
        logic          leak;
        for (int t = 0; t < nt; t++) begin
            n = 0;
            @(negedge clk);
            while (!(|req_rdy) && n < 60) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 60) begin
                errs++;
                $display("FAIL grant_timeout req_rdy=%b want one grant", req_rdy);
                return;
            end
            w = winner(req_val);
            oh = '0;
            if (w >= 0) oh[w] = 1'b1;
            checks++;
            if (req_rdy !== oh) begin
                errs++;
                $display("FAIL grant_index req_rdy=%b want %b (req_val=%b ptr=%0d)", req_rdy, oh, req_val, mptr);
            end
            if (w < 0) return;
            checks++;
            if (mul_req_msg !== {op_a[w], op_b[w]}) begin
                errs++;
                $display("FAIL req_msg got %h want %h", mul_req_msg, {op_a[w], op_b[w]});
            end
            ea = op_a[w];
            eb = op_b[w];
            @(posedge clk);
            #1;
            mptr = (w + 1) % N;
            if (keep) begin
                op_a[w] = $urandom;
                op_b[w] = $urandom;
            end else begin
                req_val[w] = 1'b0;
            end
            n = 0;
            leak = 1'b0;
            @(negedge clk);
            while (!(|resp_val) && n < 60) begin
                leak = leak | (|req_rdy) | mul_req_val;
                @(negedge clk);
                n++;
            end
            leak = leak | (|req_rdy) | mul_req_val;
            checks++;
            if (leak !== 1'b0) begin
                errs++;
                $display("FAIL busy_no_request got req_rdy/mul_req_val activity=%b want 0", leak);
            end
            checks++;
            if (resp_val !== oh) begin
                errs++;
                $display("FAIL resp_val got %b want %b", resp_val, oh);
            end
            checks++;
            if (resp_msg !== ea * eb) begin
                errs++;
                $display("FAIL resp_msg got %h want %h", resp_msg, NB'(ea * eb));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        req_val  = '1;
        resp_rdy = '1;
        #1;
        checks++;
        if ({req_rdy, resp_val, mul_req_val, mul_resp_rdy} !== '0) begin
            errs++;
            $display("FAIL reset_outputs got %b want 0", {req_rdy, resp_val, mul_req_val, mul_resp_rdy});
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        op_a[1] = 32'd3;
        op_b[1] = 32'd4;
        req_val = 4'b0010;
        serve(1, 1'b0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        op_a[0] = 32'd5;
        op_b[0] = 32'd6;
        op_a[2] = 32'd7;
        op_b[2] = 32'd8;
        req_val = 4'b0101;
        serve(2, 1'b0);
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        req_val = '1;
        serve(8, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        op_a[2] = $urandom;
        op_b[2] = $urandom;
        req_val = 4'b0100;
        serve(1, 1'b0);
        op_a[0] = $urandom;
        op_b[0] = $urandom;
        op_a[3] = $urandom;
        op_b[3] = $urandom;
        req_val = 4'b1001;
        serve(2, 1'b0);
    endtask

    task automatic test_backpressure();
        int            n;
        logic [NB-1:0] ea;
        do_reset();
        op_a[0] = $urandom;
        op_b[0] = $urandom;
        ea = op_a[0] * op_b[0];
        resp_rdy[0] = 1'b0;
        req_val = 4'b0001;
        n = 0;
        @(negedge clk);
        while (!req_rdy[0] && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_val = 4'b0010;
        mptr = 1;
        n = 0;
        @(negedge clk);
        while (!(|resp_val) && n < 60) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({mul_resp_rdy, resp_val, req_rdy} !== {1'b0, 4'b0001, 4'b0000}) begin
                errs++;
                $display("FAIL backpressure cycle %0d got rdy/val/req_rdy=%b want 0_0001_0000", c, {mul_resp_rdy, resp_val, req_rdy});
            end
            @(negedge clk);
        end
        resp_rdy[0] = 1'b1;
        #1;
        checks++;
        if ({mul_resp_rdy, resp_msg} !== {1'b1, ea}) begin
            errs++;
            $display("FAIL backpressure_release got rdy=%b msg=%h want 1 %h", mul_resp_rdy, resp_msg, ea);
        end
        @(posedge clk);
        #1;
        serve(1, 1'b0);
    endtask

    task automatic test_reset_mid_busy();
        int   n;
        logic stale;
        do_reset();
        op_a[0] = 32'h1234;
        op_b[0] = 32'h10;
        req_val = 4'b0001;
        n = 0;
        @(negedge clk);
        while (!req_rdy[0] && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_val = 4'b0100;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req_rdy, resp_val, mul_req_val, mul_resp_rdy} !== '0) begin
            errs++;
            $display("FAIL mid_busy_reset got %b want 0", {req_rdy, resp_val, mul_req_val, mul_resp_rdy});
        end
`ifdef LAB1_IMUL_ARB_PERF_EN
        checks++;
        if ({perf_txns, perf_busy} !== '0) begin
            errs++;
            $display("FAIL perf_reset got txns=%0d busy=%0d want 0 0", perf_txns, perf_busy);
        end
`endif
        @(posedge clk);
        #1;
        req_val = '0;
        reset = 1'b1;
        mptr = 0;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            stale = stale | (|resp_val) | mul_resp_rdy;
        end
        checks++;
        if (stale !== 1'b0) begin
            errs++;
            $display("FAIL stale_response got %b want 0", stale);
        end
        op_a[0] = 32'hFFFF_FFFF;
        op_b[0] = 32'd2;
        req_val = 4'b0001;
        serve(1, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 30; it++) begin
            if (req_val == '0) begin
                for (int i = 0; i < N; i++) begin
                    op_a[i] = $urandom;
                    op_b[i] = $urandom;
                end
                req_val = N'($urandom_range(1, (1 << N) - 1));
            end
            serve(1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset   = 1'b0;
        req_val = '0;
        resp_rdy = '1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
